div_ctrl: RTL and testbench
===========================

// Module: div_ctrl
// PURPOSE
//  Multi-cycle divide sequencer beside the EX stage. EX raises start_i for DIV/DIVU
//  and holds operands; div_ctrl runs 32 radix-2 restoring iterations, requests a
//  pipeline stall meanwhile, and returns {remainder, quotient} for HI/LO writeback.
// PARAMETERS
//  WIDTH   32  operand width; quotient/remainder are WIDTH each, counter is $clog2(WIDTH)+1 bits
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        reset: synchronous, active-high
//  start_i      in   1        divide request, level-held by EX until result consumed
//  annul_i      in   1        abort the current divide (flush/exception)
//  signed_i     in   1        1 = DIV (two's complement), 0 = DIVU
//  opdata1_i    in   WIDTH    dividend, sampled only in FREE when start_i=1
//  opdata2_i    in   WIDTH    divisor, sampled with opdata1_i
//  result_o     out  2*WIDTH  {remainder, quotient} = {HI, LO}
//  ready_o      out  1        result_o valid
//  stall_req_o  out  1        stall request to pipeline control
//  div_zero_o   out  1        only when DIV_ZERO_FLAG_EN defined (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=FREE, cnt=0, result_o=0, ready_o=0, div_zero_o=0; rst dominates
//    every other input, including mid-divide.
//  - States: FREE, BY_ZERO, ON, END (encodings in defines.v).
//  - FREE: start_i=1 & annul_i=0 -> divisor==0 ? BY_ZERO : ON; latch |operands| when
//    signed_i (negate if MSB set), latch signed_i and operand sign bits; cnt=0.
//    start_i=0 or annul_i=1 -> stay FREE.
//  - BY_ZERO: one cycle -> END with result_o=0.
//  - ON: one restoring step per cycle (shift partial remainder, trial-subtract
//    divisor, set quotient bit if non-negative); cnt++; after step WIDTH -> END.
//  - END: fixup: quotient negated if dividend_sign^divisor_sign, remainder negated if
//    dividend_sign (signed only); result_o registered, ready_o=1; held until start_i=0
//    -> FREE with ready_o=0.
//  - Latency: start sampled cycle 0 -> ready_o=1 in cycle WIDTH+1 (33); div by zero
//    -> ready_o=1 in cycle 2.
//  - annul_i=1 in BY_ZERO/ON/END -> FREE next cycle, ready_o=0, result_o=0; no partial
//    result ever visible.
//  - stall_req_o = start_i & ~annul_i & ~ready_o (combinational); drops in the cycle
//    ready_o rises.
//  - Overflow: signed 0x80000000 / -1 wraps: quotient 0x80000000, remainder 0.
//  - Operand changes after acceptance are ignored until return to FREE.
// CONFIGURATION
//  - DIV_ZERO_FLAG_EN defined: port div_zero_o exists; 1 in the END cycle(s) of a
//    divide-by-zero, cleared with ready_o and on annul/reset.
//  - Not defined: port absent; divide by zero is silent (result_o=0, normal handshake).
// STRUCTURE
//  - defines.v: DivFree/DivByZero/DivOn/DivEnd state codes, DivStart/DivStop,
//    DivResultReady/DivResultNotReady, StallReq; reuse RegBus and DoubleRegBus.
//  - Sub-module div_step: combinational single restoring iteration
//    ({rem,quo},divisor) -> next {rem,quo}; div_ctrl owns FSM, counter, sign fixup.
// TESTING
//  - DIVU 100/7, start held -> cycle 33 ready_o=1, result_o={32'd2, 32'd14}, stall low.
//  - DIV -100/7 -> result_o={32'hFFFFFFFE, 32'hFFFFFFF2}; DIV 100/-7 -> {32'd2, 32'hFFFFFFF2}.
//  - DIVU 5/0 -> ready_o=1 in cycle 2, result_o=0; with DIV_ZERO_FLAG_EN div_zero_o=1.
//  - DIV 0x80000000 / 0xFFFFFFFF -> {32'h0, 32'h80000000}; DIVU 0xFFFFFFFF/1 -> {0, FFFFFFFF}.
//  - annul_i pulse in ON cycle 10 -> FREE next cycle, ready_o=0, then new 9/3 gives {0,3}.
//  - rst in ON cycle 20 -> all outputs 0 next cycle; ready_o held while start_i=1 in END,
//    drops the cycle after start_i=0.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divide sequencer: FSM state codes, handshake
// levels and the architectural register width.
package div_ctrl_pkg;

   // Architectural register width (RegBus); result is {HI, LO}, twice as wide.
   localparam int unsigned RegWidth = 32;

   // Sequencer states
   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   // Handshake levels
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic StallReq          = 1'b1;
   localparam logic NoStall           = 1'b0;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// {rem, quo} is shifted left by one; the divisor is trial-subtracted from the
// widened partial remainder and the quotient bit shifted in records success.
module div_step
   import div_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = RegWidth
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             ge;

   // Trial subtraction; rem < divisor on entry, so a successful difference fits WIDTH bits
   always_comb begin
      shifted = {rem_i, quo_i[WIDTH-1]};
      ge      = (shifted >= {1'b0, divisor_i});
      diff    = shifted[WIDTH-1:0] - divisor_i;
      rem_o   = ge ? diff : shifted[WIDTH-1:0];
      quo_o   = {quo_i[WIDTH-2:0], ge};
   end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle divide sequencer next to EX. Accepts a DIV/DIVU request, runs
// WIDTH restoring iterations through div_step while stalling the pipeline, applies
// the sign fixup and presents {remainder, quotient} until EX drops start_i.
// Optional feature macro: DIV_ZERO_FLAG_EN adds the div_zero_o output.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = RegWidth
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               annul_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
`ifdef DIV_ZERO_FLAG_EN
   output logic               div_zero_o,
`endif
   output logic               stall_req_o
);

   localparam int unsigned   CntW    = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] One    = {{(WIDTH-1){1'b0}}, 1'b1};

   div_state_e         state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               ready_q, ready_d;
   logic               dz_q, dz_d;

   logic [WIDTH-1:0]   step_rem, step_quo;
   logic [WIDTH-1:0]   fix_rem, fix_quo;
   logic               op1_neg, op2_neg;

   div_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   // Operand signs and sign fixup of the final iteration's output
   always_comb begin
      op1_neg = signed_i & opdata1_i[WIDTH-1];
      op2_neg = signed_i & opdata2_i[WIDTH-1];
      fix_quo = neg_quo_q ? (~step_quo + One) : step_quo;
      fix_rem = neg_rem_q ? (~step_rem + One) : step_rem;
   end

   // Next-state logic: accept, iterate, fix up, hold, and abort on annul
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      ready_d   = ready_q;
      dz_d      = dz_q;

      unique case (state_q)
         DivFree: begin
            if (start_i == DivStart && !annul_i) begin
               // Work on magnitudes; 0x80..0 negates to itself, which is its magnitude
               rem_d     = '0;
               quo_d     = op1_neg ? (~opdata1_i + One) : opdata1_i;
               dvs_d     = op2_neg ? (~opdata2_i + One) : opdata2_i;
               neg_quo_d = op1_neg ^ op2_neg;
               neg_rem_d = op1_neg;
               cnt_d     = '0;
               state_d   = (opdata2_i == '0) ? DivByZero : DivOn;
            end
         end
         DivByZero: begin
            if (annul_i) begin
               state_d  = DivFree;
               result_d = '0;
               ready_d  = DivResultNotReady;
               dz_d     = 1'b0;
            end else begin
               state_d  = DivEnd;
               result_d = '0;
               ready_d  = DivResultReady;
               dz_d     = 1'b1;
            end
         end
         DivOn: begin
            if (annul_i) begin
               state_d  = DivFree;
               result_d = '0;
               ready_d  = DivResultNotReady;
               dz_d     = 1'b0;
            end else begin
               rem_d = step_rem;
               quo_d = step_quo;
               cnt_d = cnt_q + 1'b1;
               // Result registered on the same edge as the last step so ready rises in END
               if (cnt_q == LastCnt) begin
                  state_d  = DivEnd;
                  result_d = {fix_rem, fix_quo};
                  ready_d  = DivResultReady;
               end
            end
         end
         DivEnd: begin
            if (annul_i || start_i == DivStop) begin
               state_d  = DivFree;
               result_d = '0;
               ready_d  = DivResultNotReady;
               dz_d     = 1'b0;
               cnt_d    = '0;
            end
         end
         default: begin
            state_d = DivFree;
         end
      endcase
   end

   // State and datapath registers; synchronous reset wins over everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DivFree;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         ready_q   <= DivResultNotReady;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
         dz_q      <= dz_d;
      end
   end

   // Outputs; stall is combinational so it drops in the cycle ready rises
   always_comb begin
      result_o    = result_q;
      ready_o     = ready_q;
      stall_req_o = (start_i == DivStart && !annul_i && ready_q == DivResultNotReady) ?
                    StallReq : NoStall;
   end

`ifdef DIV_ZERO_FLAG_EN
   assign div_zero_o = dz_q;
`else
   // Flag is only observable when the port exists
   logic unused_dz;
   assign unused_dz = dz_q;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: scoreboard of expected {rem, quo} pushed at
// launch and popped when ready_o rises; one task per scenario.
module tb_div_ctrl;

   localparam int W = 32;

   logic           clk;
   logic           rst;
   logic           start_i;
   logic           annul_i;
   logic           signed_i;
   logic [W-1:0]   opdata1_i;
   logic [W-1:0]   opdata2_i;
   logic [2*W-1:0] result_o;
   logic           ready_o;
   logic           stall_req_o;
`ifdef DIV_ZERO_FLAG_EN
   logic           div_zero_o;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [2*W-1:0] exp_q[$];
   logic [W-1:0]   lat_q[$];

   div_ctrl #(
      .WIDTH (W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .annul_i     (annul_i),
      .signed_i    (signed_i),
      .opdata1_i   (opdata1_i),
      .opdata2_i   (opdata2_i),
      .result_o    (result_o),
      .ready_o     (ready_o),
`ifdef DIV_ZERO_FLAG_EN
      .div_zero_o  (div_zero_o),
`endif
      .stall_req_o (stall_req_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model built from ordinary SV arithmetic
   function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic signed [W-1:0] sa, sb, sq, sr;
      if (b == '0) return '0;
      if (!s) return {a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
   endfunction

   task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      signed_i  = s;
      opdata1_i = a;
      opdata2_i = b;
      annul_i   = 1'b0;
      start_i   = 1'b1;
      exp_q.push_back(model(s, a, b));
      lat_q.push_back((b == '0) ? 32'd2 : 32'd33);
   endtask

   // Clock edges until ready_o or budget; scrambles operands after acceptance and
   // counts cycles where stall_req_o disagreed with ~ready_o.
   task automatic wait_ready(output int lat, output int stall_bad);
      lat = 0;
      stall_bad = 0;
      while (lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) begin
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            signed_i  = ~signed_i;
         end
         if (stall_req_o !== ~ready_o) stall_bad++;
         if (ready_o === 1'b1) break;
      end
   endtask

   task automatic step_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start_i = 1'b0;
      annul_i = 1'b0;
      signed_i = 1'b0;
      opdata1_i = '0;
      opdata2_i = '0;
      step_cycles(2);
      n_cmp++;
      if (result_o !== '0) begin
         n_err++;
         $display("FAIL reset_result got=%h want=0", result_o);
      end
      n_cmp++;
      if (ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ready got=%b want=0", ready_o);
      end
      n_cmp++;
      if (stall_req_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_stall got=%b want=0", stall_req_o);
      end
`ifdef DIV_ZERO_FLAG_EN
      n_cmp++;
      if (div_zero_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_dz got=%b want=0", div_zero_o);
      end
`endif
      rst = 1'b0;
      step_cycles(1);
   endtask

   // Runs a table of divides through the full handshake
   task automatic test_divides();
      logic [W-1:0] ta[8] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'h8000_0000,
                              32'hFFFF_FFFF, 32'd7, 32'hDEAD_BEEF, 32'h8000_0001};
      logic [W-1:0] tb[8] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                              32'd1, 32'd9, 32'd3, 32'hFFFF_FFFE};
      logic         ts[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      int lat, sbad;
      logic [2*W-1:0] exp;
      logic [W-1:0]   elat;
      for (int i = 0; i < 8; i++) begin
         launch(ts[i], ta[i], tb[i]);
         #1;
         n_cmp++;
         if (stall_req_o !== 1'b1) begin
            n_err++;
            $display("FAIL div%0d_stall_start got=%b want=1", i, stall_req_o);
         end
         wait_ready(lat, sbad);
         exp  = exp_q.pop_front();
         elat = lat_q.pop_front();
         n_cmp++;
         if (lat !== int'(elat)) begin
            n_err++;
            $display("FAIL div%0d_latency got=%0d want=%0d", i, lat, elat);
         end
         n_cmp++;
         if (result_o !== exp) begin
            n_err++;
            $display("FAIL div%0d_result got=%h want=%h", i, result_o, exp);
         end
         n_cmp++;
         if (sbad !== 0) begin
            n_err++;
            $display("FAIL div%0d_stall got=%0d bad cycles want=0", i, sbad);
         end
         start_i = 1'b0;
         step_cycles(1);
         n_cmp++;
         if (ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL div%0d_release got=%b want=0", i, ready_o);
         end
      end
   endtask

   task automatic test_div_zero();
      int lat, sbad;
      logic [2*W-1:0] exp;
      logic [W-1:0]   elat;
      launch(1'b0, 32'd5, 32'd0);
      wait_ready(lat, sbad);
      exp  = exp_q.pop_front();
      elat = lat_q.pop_front();
      n_cmp++;
      if (lat !== int'(elat)) begin
         n_err++;
         $display("FAIL dz_latency got=%0d want=%0d", lat, elat);
      end
      n_cmp++;
      if (result_o !== exp) begin
         n_err++;
         $display("FAIL dz_result got=%h want=%h", result_o, exp);
      end
`ifdef DIV_ZERO_FLAG_EN
      n_cmp++;
      if (div_zero_o !== 1'b1) begin
         n_err++;
         $display("FAIL dz_flag got=%b want=1", div_zero_o);
      end
`endif
      start_i = 1'b0;
      step_cycles(1);
      n_cmp++;
      if (ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL dz_release got=%b want=0", ready_o);
      end
`ifdef DIV_ZERO_FLAG_EN
      n_cmp++;
      if (div_zero_o !== 1'b0) begin
         n_err++;
         $display("FAIL dz_flag_clear got=%b want=0", div_zero_o);
      end
`endif
   endtask

   task automatic test_annul();
      int lat, sbad;
      logic [2*W-1:0] exp;
      logic [W-1:0]   elat;
      launch(1'b0, 32'd1000, 32'd3);
      step_cycles(10);
      annul_i = 1'b1;
      #1;
      n_cmp++;
      if (stall_req_o !== 1'b0) begin
         n_err++;
         $display("FAIL annul_stall got=%b want=0", stall_req_o);
      end
      void'(exp_q.pop_back());
      void'(lat_q.pop_back());
      step_cycles(1);
      annul_i = 1'b0;
      start_i = 1'b0;
      #1;
      n_cmp++;
      if (ready_o !== 1'b0 || result_o !== '0) begin
         n_err++;
         $display("FAIL annul_outputs got=%b/%h want=0/0", ready_o, result_o);
      end
      step_cycles(1);
      launch(1'b0, 32'd9, 32'd3);
      wait_ready(lat, sbad);
      exp  = exp_q.pop_front();
      elat = lat_q.pop_front();
      n_cmp++;
      if (lat !== int'(elat) || result_o !== exp) begin
         n_err++;
         $display("FAIL annul_next got=%0d/%h want=%0d/%h", lat, result_o, elat, exp);
      end
      start_i = 1'b0;
      step_cycles(1);
   endtask

   task automatic test_reset_mid();
      int lat, sbad;
      logic [2*W-1:0] exp;
      logic [W-1:0]   elat;
      launch(1'b1, 32'hFFFF_0000, 32'd17);
      step_cycles(20);
      rst = 1'b1;
      start_i = 1'b0;
      void'(exp_q.pop_back());
      void'(lat_q.pop_back());
      step_cycles(1);
      n_cmp++;
      if (ready_o !== 1'b0 || result_o !== '0 || stall_req_o !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid got=%b/%h/%b want=0/0/0", ready_o, result_o, stall_req_o);
      end
      rst = 1'b0;
      step_cycles(1);
      // Hold start in END: result must stay visible until start drops
      launch(1'b0, 32'd7, 32'd2);
      wait_ready(lat, sbad);
      exp  = exp_q.pop_front();
      elat = lat_q.pop_front();
      n_cmp++;
      if (lat !== int'(elat) || result_o !== exp) begin
         n_err++;
         $display("FAIL hold_first got=%0d/%h want=%0d/%h", lat, result_o, elat, exp);
      end
      for (int i = 0; i < 5; i++) begin
         step_cycles(1);
         n_cmp++;
         if (ready_o !== 1'b1 || result_o !== exp || stall_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL hold_cycle%0d got=%b/%h/%b want=1/%h/0", i, ready_o, result_o,
                     stall_req_o, exp);
         end
      end
      start_i = 1'b0;
      #1;
      n_cmp++;
      if (ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL hold_drop_same got=%b want=1", ready_o);
      end
      step_cycles(1);
      n_cmp++;
      if (ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL hold_drop_next got=%b want=0", ready_o);
      end
   endtask

   task automatic test_random();
      int lat, sbad;
      logic [2*W-1:0] exp;
      logic [W-1:0]   elat;
      logic [W-1:0]   a, b;
      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         b = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
         launch(1'($urandom_range(0, 1)), a, b);
         wait_ready(lat, sbad);
         exp  = exp_q.pop_front();
         elat = lat_q.pop_front();
         n_cmp++;
         if (lat !== int'(elat) || result_o !== exp || sbad !== 0) begin
            n_err++;
            $display("FAIL rand%0d got=%0d/%h/%0d want=%0d/%h/0", i, lat, result_o, sbad,
                     elat, exp);
         end
         start_i = 1'b0;
         step_cycles(1);
      end
   endtask

   initial begin
      test_reset();
      test_divides();
      test_div_zero();
      test_annul();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
